// File: rtl/point_sub_if.sv
// Shared point type and field helpers, plus the start/done request interface
// between a point_sub requester and the subtractor.
package point_sub_pkg;
    localparam int COORD_W = 256;

    typedef logic [COORD_W-1:0] felem_t;

    typedef struct packed {
        logic   inf;
        felem_t x;
        felem_t y;
    } curve_point_t;

    localparam curve_point_t INF_POINT = '{inf: 1'b1, x: '0, y: '0};

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_INV, S_MUL_S, S_MUL_S2, S_MUL_Y, S_DONE
    } state_e;

    // Operands are assumed already reduced below p.
    function automatic felem_t mod_add(input felem_t a, input felem_t b, input felem_t p);
        logic [COORD_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, p}) s = s - {1'b0, p};
        return s[COORD_W-1:0];
    endfunction

    function automatic felem_t mod_sub(input felem_t a, input felem_t b, input felem_t p);
        return (a >= b) ? a - b : a + (p - b);
    endfunction
endpackage

interface point_sub_if;
    import point_sub_pkg::*;

    logic         start;
    curve_point_t P;
    curve_point_t Q;
    logic         busy;
    logic         done;
    logic         err;
    curve_point_t R;

    modport master (output start, P, Q, input busy, done, err, R);
    modport slave  (input start, P, Q, output busy, done, err, R);
endinterface

// File: rtl/point_sub.sv
// Affine point subtraction R = P - Q over GF(P_MOD), sequenced around one
// shared bit-serial multiplier and one binary-GCD modular inverter.
module mod_mul
    import point_sub_pkg::*;
#(
    parameter felem_t P_MOD = felem_t'(17)
) (
    input  logic   clk,
    input  logic   rst_i,
    input  felem_t a_i,
    input  felem_t b_i,
    output logic   done_o,
    output felem_t y_o
);
    localparam int IW = $clog2(COORD_W);

    felem_t        acc_q, acc_d;
    logic [IW-1:0] idx_q;
    logic          done_q;

    // MSB-first double-and-add over the bits of b.
    always_comb begin
        acc_d = mod_add(acc_q, acc_q, P_MOD);
        if (b_i[idx_q]) acc_d = mod_add(acc_d, a_i, P_MOD);
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            acc_q  <= '0;
            idx_q  <= IW'(COORD_W - 1);
            done_q <= 1'b0;
        end else if (!done_q) begin
            acc_q <= acc_d;
            if (idx_q == '0) done_q <= 1'b1;
            else             idx_q  <= idx_q - IW'(1);
        end
    end

    assign done_o = done_q;
    assign y_o    = acc_q;
endmodule

module mod_inv
    import point_sub_pkg::*;
#(
    parameter felem_t P_MOD = felem_t'(17)
) (
    input  logic   clk,
    input  logic   rst_i,
    input  felem_t a_i,
    output logic   done_o,
    output felem_t y_o
);
    felem_t u_q, v_q, x1_q, x2_q, y_q;
    logic   done_q;

    function automatic felem_t half(input felem_t x);
        logic [COORD_W:0] t;
        t = x[0] ? ({1'b0, x} + {1'b0, P_MOD}) : {1'b0, x};
        return t[COORD_W:1];
    endfunction

    // Invariants: x1*a == u and x2*a == v (mod p); a must be nonzero.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            u_q    <= a_i;
            v_q    <= P_MOD;
            x1_q   <= felem_t'(1);
            x2_q   <= '0;
            y_q    <= '0;
            done_q <= 1'b0;
        end else if (!done_q) begin
            if (u_q == felem_t'(1)) begin
                y_q    <= x1_q;
                done_q <= 1'b1;
            end else if (v_q == felem_t'(1)) begin
                y_q    <= x2_q;
                done_q <= 1'b1;
            end else if (!u_q[0]) begin
                u_q  <= u_q >> 1;
                x1_q <= half(x1_q);
            end else if (!v_q[0]) begin
                v_q  <= v_q >> 1;
                x2_q <= half(x2_q);
            end else if (u_q >= v_q) begin
                u_q  <= u_q - v_q;
                x1_q <= mod_sub(x1_q, x2_q, P_MOD);
            end else begin
                v_q  <= v_q - u_q;
                x2_q <= mod_sub(x2_q, x1_q, P_MOD);
            end
        end
    end

    assign done_o = done_q;
    assign y_o    = y_q;
endmodule

module point_sub
    import point_sub_pkg::*;
#(
    parameter int     WIDTH = COORD_W,
    parameter felem_t P_MOD = felem_t'(17)
) (
    input  logic       clk,
    input  logic       Reset,
    point_sub_if.slave io
);
    typedef logic [WIDTH-1:0] coord_t;

    state_e       state_q, state_d;
    logic         arm_q;
    curve_point_t pl_q, ql_q, r_q;
    logic         err_q;
    coord_t       inv_q, s_q, rx_q;

    logic         busy, done, inv_rst, mul_rst;
    logic         inv_done, mul_done, inv_cap, mul_cap;
    coord_t       inv_a, inv_y, mul_a, mul_b, mul_y;
    logic         special, spec_err;
    curve_point_t spec_r;

    always_ff @(posedge clk) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Low for the first cycle of every state, so each sub-unit run begins
    // with one cycle of reset.
    always_ff @(posedge clk) begin
        if (Reset) arm_q <= 1'b0;
        else       arm_q <= (state_d == state_q);
    end

    always_comb begin
        special  = 1'b1;
        spec_err = 1'b0;
        spec_r   = INF_POINT;
        if (pl_q.inf && ql_q.inf) spec_r = INF_POINT;
        else if (pl_q.inf)        spec_r = '{inf: 1'b0, x: ql_q.x, y: mod_sub('0, ql_q.y, P_MOD)};
        else if (ql_q.inf)        spec_r = pl_q;
        else if (pl_q.x == ql_q.x) spec_err = (pl_q.y != ql_q.y);
        else                      special = 1'b0;
    end

    assign inv_cap = (state_q == S_INV) && arm_q && inv_done;
    assign mul_cap = (state_q inside {S_MUL_S, S_MUL_S2, S_MUL_Y}) && arm_q && mul_done;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (io.start) state_d = S_CHECK;
            S_CHECK:  state_d = special ? S_DONE : S_INV;
            S_INV:    if (inv_cap) state_d = S_MUL_S;
            S_MUL_S:  if (mul_cap) state_d = S_MUL_S2;
            S_MUL_S2: if (mul_cap) state_d = S_MUL_Y;
            S_MUL_Y:  if (mul_cap) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = !(state_q inside {S_IDLE, S_DONE});
        done    = (state_q == S_DONE);
        inv_rst = Reset || !((state_q == S_INV) && arm_q);
        mul_rst = Reset || !((state_q inside {S_MUL_S, S_MUL_S2, S_MUL_Y}) && arm_q);
    end

    always_comb begin
        inv_a = mod_sub(pl_q.x, ql_q.x, P_MOD);
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_MUL_S: begin
                mul_a = mod_add(pl_q.y, ql_q.y, P_MOD);
                mul_b = inv_q;
            end
            S_MUL_S2: begin
                mul_a = s_q;
                mul_b = s_q;
            end
            S_MUL_Y: begin
                mul_a = s_q;
                mul_b = mod_sub(pl_q.x, rx_q, P_MOD);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_q   <= INF_POINT;
            err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  if (io.start) err_q <= 1'b0;
                S_CHECK: if (special) begin
                    r_q   <= spec_r;
                    err_q <= spec_err;
                end
                S_MUL_Y: if (mul_cap) r_q <= '{inf: 1'b0, x: rx_q, y: mod_sub(mul_y, pl_q.y, P_MOD)};
                default: ;
            endcase
        end
    end

    // NOTE: working registers carry no reset; each is written before it is
    // read in any run, so a reset term would only add fan-out on Reset.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && io.start) begin
            pl_q <= io.P;
            ql_q <= io.Q;
        end
        if (inv_cap) inv_q <= inv_y;
        if (mul_cap && state_q == S_MUL_S)  s_q  <= mul_y;
        if (mul_cap && state_q == S_MUL_S2) rx_q <= mod_sub(mul_y, mod_add(pl_q.x, ql_q.x, P_MOD), P_MOD);
    end

    mod_inv #(.P_MOD(P_MOD)) u_inv (
        .clk    (clk),
        .rst_i  (inv_rst),
        .a_i    (inv_a),
        .done_o (inv_done),
        .y_o    (inv_y)
    );

    mod_mul #(.P_MOD(P_MOD)) u_mul (
        .clk    (clk),
        .rst_i  (mul_rst),
        .a_i    (mul_a),
        .b_i    (mul_b),
        .done_o (mul_done),
        .y_o    (mul_y)
    );

    assign io.busy = busy;
    assign io.done = done;
    assign io.err  = err_q;
    assign io.R    = r_q;
endmodule

// File: tb/tb_point_sub.sv
// Scoreboard bench for point_sub on y^2 = x^3 + 2x + 2 over GF(17).
module tb_point_sub;
    import point_sub_pkg::*;

    typedef logic [1023:0] wide_t;
    typedef struct {
        curve_point_t r;
        logic         err;
    } exp_t;

    localparam int LIMIT = 5000;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    point_sub_if bus ();

    point_sub #(.WIDTH(COORD_W), .P_MOD(felem_t'(17))) dut (
        .clk   (clk),
        .Reset (Reset),
        .io    (bus)
    );

    exp_t sb_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   exp_dones = 0;

    function automatic curve_point_t pt(input int x, input int y);
        return '{inf: 1'b0, x: felem_t'(x), y: felem_t'(y)};
    endfunction

    task automatic check(input string name, input wide_t act, input wide_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!Reset && bus.done) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("R", wide_t'(bus.R), wide_t'(e.r));
                check("err", wide_t'(bus.err), wide_t'(e.err));
            end
        end
    end

    task automatic issue(input curve_point_t p, input curve_point_t q,
                         input curve_point_t er, input logic ee);
        exp_t e;
        e.r = er;
        e.err = ee;
        bus.start = 1'b1;
        bus.P = p;
        bus.Q = q;
        sb_q.push_back(e);
        exp_dones++;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.P = pt(3, 7);
        bus.Q = pt(9, 2);
    endtask

    // Returns cycles from start to done; leaves the bench in the IDLE cycle.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.done) begin
            check("done_timeout", 0, 1);
            void'(sb_q.pop_back());
            exp_dones--;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        bus.start = 1'b0;
        bus.P = INF_POINT;
        bus.Q = INF_POINT;
        Reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", wide_t'(bus.busy), 0);
        check("rst_done", wide_t'(bus.done), 0);
        check("rst_err", wide_t'(bus.err), 0);
        check("rst_R", wide_t'(bus.R), wide_t'(INF_POINT));
        Reset = 1'b0;
        @(posedge clk); #1;

        // 3G - G = 2G
        issue(pt(10, 6), pt(5, 1), pt(6, 3), 1'b0);
        check("busy_after_start", wide_t'(bus.busy), 1);
        wait_done(lat);
        check("s_internal", wide_t'(dut.s_q), 15);

        // 2G - G = G, with a start pulse while busy that must be ignored
        issue(pt(6, 3), pt(5, 1), pt(5, 1), 1'b0);
        repeat (20) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.P = pt(10, 6);
        bus.Q = pt(5, 1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat);

        issue(INF_POINT, pt(5, 1), pt(5, 16), 1'b0);
        wait_done(lat);
        check("lat_inf_p", lat, 2);

        issue(pt(5, 1), INF_POINT, pt(5, 1), 1'b0);
        wait_done(lat);
        check("lat_inf_q", lat, 2);

        // Abort in MUL_S2: outputs return to reset values, no done pulse
        issue(pt(10, 6), pt(5, 1), pt(6, 3), 1'b0);
        lat = 0;
        while (dut.state_q != S_MUL_S2 && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        check("reach_mul_s2", wide_t'(dut.state_q == S_MUL_S2), 1);
        Reset = 1'b1;
        @(posedge clk); #1;
        Reset = 1'b0;
        void'(sb_q.pop_back());
        exp_dones--;
        check("abort_busy", wide_t'(bus.busy), 0);
        check("abort_done", wide_t'(bus.done), 0);
        check("abort_R", wide_t'(bus.R), wide_t'(INF_POINT));
        repeat (5) @(posedge clk);
        #1;
        issue(pt(10, 6), pt(5, 1), pt(6, 3), 1'b0);
        wait_done(lat);

        issue(pt(5, 1), pt(5, 1), INF_POINT, 1'b0);
        wait_done(lat);
        issue(pt(5, 1), pt(5, 16), INF_POINT, 1'b1);
        wait_done(lat);

        issue(INF_POINT, INF_POINT, INF_POINT, 1'b0);
        check("err_clear_on_start", wide_t'(bus.err), 0);
        wait_done(lat);

        // Back-to-back: second start the cycle after the first done
        issue(pt(10, 6), pt(5, 1), pt(6, 3), 1'b0);
        wait_done(lat);
        issue(pt(6, 3), pt(5, 1), pt(5, 1), 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("R_held_mid_op", wide_t'(bus.R), wide_t'(pt(6, 3)));
        wait_done(lat);

        repeat (5) @(posedge clk);
        #1;
        check("done_count", done_cnt, exp_dones);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
